// File: rtl/falafel_req_arbiter_if.sv
// Client/core bundle for falafel_req_arbiter: client request/response channels plus the
// FIFO-compatible alloc, free and response slots seen by falafel_core.
interface falafel_req_arbiter_if #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned TAG_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);

    logic [NUM_CH-1:0]        req_val_i;
    logic [NUM_CH-1:0]        req_is_free_i;
    logic [NUM_CH*DATA_W-1:0] req_data_i;
    logic [NUM_CH-1:0]        req_rdy_o;
    logic [NUM_CH-1:0]        rsp_val_o;
    logic [DATA_W-1:0]        rsp_data_o;
    logic [NUM_CH-1:0]        rsp_rdy_i;
    logic                     alloc_fifo_empty_o;
    logic                     alloc_fifo_read_i;
    logic [DATA_W-1:0]        alloc_fifo_dout_o;
    logic                     free_fifo_empty_o;
    logic                     free_fifo_read_i;
    logic [DATA_W-1:0]        free_fifo_dout_o;
    logic                     resp_fifo_full_o;
    logic                     resp_fifo_write_i;
    logic [DATA_W-1:0]        resp_fifo_din_i;
    logic [CNT_W-1:0]         outstanding_o;
    logic                     tag_underflow_o;

    modport slave (
        input  req_val_i, req_is_free_i, req_data_i, rsp_rdy_i,
               alloc_fifo_read_i, free_fifo_read_i, resp_fifo_write_i, resp_fifo_din_i,
        output req_rdy_o, rsp_val_o, rsp_data_o, alloc_fifo_empty_o, alloc_fifo_dout_o,
               free_fifo_empty_o, free_fifo_dout_o, resp_fifo_full_o, outstanding_o,
               tag_underflow_o
    );

    modport master (
        output req_val_i, req_is_free_i, req_data_i, rsp_rdy_i,
               alloc_fifo_read_i, free_fifo_read_i, resp_fifo_write_i, resp_fifo_din_i,
        input  req_rdy_o, rsp_val_o, rsp_data_o, alloc_fifo_empty_o, alloc_fifo_dout_o,
               free_fifo_empty_o, free_fifo_dout_o, resp_fifo_full_o, outstanding_o,
               tag_underflow_o
    );
endinterface

// File: rtl/falafel_req_arbiter.sv
// Round-robin arbiter of NUM_CH client alloc/free channels onto falafel_core's FIFO slots,
// with tag-FIFO response routing. Define FALAFEL_ARB_FREE_FIRST_EN to give frees priority.
module falafel_req_arbiter #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned TAG_DEPTH = 8
) (
    input logic                  clk_i,
    input logic                  rst_i,
    falafel_req_arbiter_if.slave bus
);
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);

    logic              alloc_vld_q, free_vld_q, rsp_vld_q, underflow_q;
    logic [DATA_W-1:0] alloc_data_q, free_data_q, rsp_data_q;
    logic [CH_W-1:0]   rr_q, rsp_ch_q;
    logic [CH_W-1:0]   tag_q [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              alloc_read, free_read, alloc_space, free_space, tag_full, tag_empty;
    logic [NUM_CH-1:0] elig_free, elig_alloc, elig, req_rdy, rsp_val;
    logic              grant_vld, grant_free, tag_push, tag_pop, rsp_clear;
    logic [CH_W-1:0]   grant_ch, rr_d;
    logic [DATA_W-1:0] grant_data;

    assign alloc_read  = bus.alloc_fifo_read_i & alloc_vld_q;
    assign free_read   = bus.free_fifo_read_i & free_vld_q;
    assign alloc_space = !alloc_vld_q | alloc_read;
    assign free_space  = !free_vld_q | free_read;
    assign tag_full    = (cnt_q == CNT_W'(TAG_DEPTH));
    assign tag_empty   = (cnt_q == '0);

    // Eligibility sees the pre-pop tag count, so a full tag FIFO always blocks allocs.
    always_comb begin
        elig_free  = bus.req_val_i & bus.req_is_free_i & {NUM_CH{free_space}};
        elig_alloc = bus.req_val_i & ~bus.req_is_free_i & {NUM_CH{alloc_space & !tag_full}};
`ifdef FALAFEL_ARB_FREE_FIRST_EN
        elig = (|elig_free) ? elig_free : elig_alloc;
`else
        elig = elig_free | elig_alloc;
`endif
        if (rst_i) elig = '0;
    end

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_vld && elig[CH_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        grant_data = '0;
        req_rdy    = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == grant_ch) grant_data = bus.req_data_i[c*DATA_W +: DATA_W];
        end
        if (grant_vld) req_rdy[grant_ch] = 1'b1;
        grant_free = bus.req_is_free_i[grant_ch];
        rr_d       = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
    end

    assign tag_push  = grant_vld & !grant_free;
    assign tag_pop   = bus.resp_fifo_write_i & !rsp_vld_q & !tag_empty;
    assign rsp_clear = rsp_vld_q & bus.rsp_rdy_i[rsp_ch_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_vld_q  <= 1'b0;
            alloc_data_q <= '0;
            free_vld_q   <= 1'b0;
            free_data_q  <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_data_q   <= '0;
            rsp_ch_q     <= '0;
            underflow_q  <= 1'b0;
            rr_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
        end else begin
            if (grant_vld) rr_q <= rr_d;

            if (grant_vld && !grant_free) begin
                alloc_vld_q  <= 1'b1;
                alloc_data_q <= grant_data;
            end else if (alloc_read) begin
                alloc_vld_q <= 1'b0;
            end

            if (grant_vld && grant_free) begin
                free_vld_q  <= 1'b1;
                free_data_q <= grant_data;
            end else if (free_read) begin
                free_vld_q <= 1'b0;
            end

            if (tag_push) begin
                tag_q[wr_ptr_q] <= grant_ch;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (tag_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({tag_push, tag_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase

            if (tag_pop) begin
                rsp_vld_q  <= 1'b1;
                rsp_data_q <= bus.resp_fifo_din_i;
                rsp_ch_q   <= tag_q[rd_ptr_q];
            end else if (rsp_clear) begin
                rsp_vld_q <= 1'b0;
            end

            // A core response with no alloc to route it to is dropped and flagged.
            if (bus.resp_fifo_write_i && tag_empty) underflow_q <= 1'b1;
        end
    end

    always_comb begin
        rsp_val = '0;
        if (rsp_vld_q) rsp_val[rsp_ch_q] = 1'b1;
    end

    assign bus.req_rdy_o          = req_rdy;
    assign bus.rsp_val_o          = rsp_val;
    assign bus.rsp_data_o         = rsp_vld_q ? rsp_data_q : '0;
    assign bus.alloc_fifo_empty_o = !alloc_vld_q;
    assign bus.alloc_fifo_dout_o  = alloc_data_q;
    assign bus.free_fifo_empty_o  = !free_vld_q;
    assign bus.free_fifo_dout_o   = free_data_q;
    assign bus.resp_fifo_full_o   = rsp_vld_q;
    assign bus.outstanding_o      = cnt_q;
    assign bus.tag_underflow_o    = underflow_q;
endmodule

// File: tb/tb_falafel_req_arbiter.sv
// Directed bench for falafel_req_arbiter: reset, single alloc, round-robin routing, tag-full
// stall, underflow and free/alloc priority, all with hand-computed expectations.
module tb_falafel_req_arbiter;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned TAG_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    falafel_req_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) bus ();

    falafel_req_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_first;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_val_i         = '0;
        bus.req_is_free_i     = '0;
        bus.req_data_i        = '0;
        bus.rsp_rdy_i         = '0;
        bus.alloc_fifo_read_i = 1'b0;
        bus.free_fifo_read_i  = 1'b0;
        bus.resp_fifo_write_i = 1'b0;
        bus.resp_fifo_din_i   = '0;
    endtask

    task automatic set_data(input int c, input logic [63:0] d);
        bus.req_data_i[c*DATA_W +: DATA_W] = d;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, ".req_rdy"},     64'(bus.req_rdy_o), 64'h0);
        check({p, ".rsp_val"},     64'(bus.rsp_val_o), 64'h0);
        check({p, ".rsp_data"},    64'(bus.rsp_data_o), 64'h0);
        check({p, ".alloc_empty"}, 64'(bus.alloc_fifo_empty_o), 64'h1);
        check({p, ".free_empty"},  64'(bus.free_fifo_empty_o), 64'h1);
        check({p, ".resp_full"},   64'(bus.resp_fifo_full_o), 64'h0);
        check({p, ".alloc_dout"},  64'(bus.alloc_fifo_dout_o), 64'h0);
        check({p, ".free_dout"},   64'(bus.free_fifo_dout_o), 64'h0);
        check({p, ".outstanding"}, 64'(bus.outstanding_o), 64'h0);
        check({p, ".underflow"},   64'(bus.tag_underflow_o), 64'h0);
    endtask

    initial begin
        idle();
        tick();
        tick();
        check_reset_vals("init");
        rst = 1'b0;

        // Single alloc from ch2 and its response.
        bus.req_val_i = 4'b0100;
        set_data(2, 64'h40);
        #1 check("single.req_rdy", 64'(bus.req_rdy_o), 64'h4);
        tick();
        idle();
        check("single.alloc_empty", 64'(bus.alloc_fifo_empty_o), 64'h0);
        check("single.alloc_dout", 64'(bus.alloc_fifo_dout_o), 64'h40);
        check("single.outstanding", 64'(bus.outstanding_o), 64'h1);
        bus.alloc_fifo_read_i = 1'b1;
        tick();
        idle();
        check("single.alloc_consumed", 64'(bus.alloc_fifo_empty_o), 64'h1);
        bus.resp_fifo_write_i = 1'b1;
        bus.resp_fifo_din_i   = 64'h1000;
        tick();
        idle();
        check("single.rsp_val", 64'(bus.rsp_val_o), 64'h4);
        check("single.rsp_data", 64'(bus.rsp_data_o), 64'h1000);
        check("single.resp_full", 64'(bus.resp_fifo_full_o), 64'h1);
        check("single.outstanding0", 64'(bus.outstanding_o), 64'h0);
        bus.rsp_rdy_i = 4'b0100;
        #1 check("single.full_not_comb", 64'(bus.resp_fifo_full_o), 64'h1);
        tick();
        idle();
        check("single.full_cleared", 64'(bus.resp_fifo_full_o), 64'h0);
        check("single.rsp_val_cleared", 64'(bus.rsp_val_o), 64'h0);

        // Build 3 outstanding allocs (rr starts at ch3), then reset mid-traffic.
        bus.req_val_i         = 4'b1111;
        bus.alloc_fifo_read_i = 1'b1;
        for (int c = 0; c < 4; c++) set_data(c, 64'h20 + 64'(c));
        tick();
        tick();
        tick();
        check("mid.outstanding3", 64'(bus.outstanding_o), 64'h3);
        rst = 1'b1;
        tick();
        check_reset_vals("rst_mid");
        rst = 1'b0;
        idle();

        // Round-robin: all channels alloc, core reads every cycle.
        bus.req_val_i         = 4'b1111;
        bus.alloc_fifo_read_i = 1'b1;
        for (int c = 0; c < 4; c++) set_data(c, 64'h10 + 64'(c));
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("rr.grant%0d", k), 64'(bus.req_rdy_o), 64'(1) << k);
            tick();
            if (k == 3) bus.req_val_i = '0;
            check($sformatf("rr.dout%0d", k), 64'(bus.alloc_fifo_dout_o), 64'h10 + 64'(k));
        end
        tick();
        idle();
        check("rr.outstanding4", 64'(bus.outstanding_o), 64'h4);
        check("rr.alloc_empty", 64'(bus.alloc_fifo_empty_o), 64'h1);
        for (int k = 0; k < 4; k++) begin
            bus.resp_fifo_write_i = 1'b1;
            bus.resp_fifo_din_i   = 64'hA0 + 64'(k);
            tick();
            bus.resp_fifo_write_i = 1'b0;
            check($sformatf("rr.rsp_val%0d", k), 64'(bus.rsp_val_o), 64'(1) << k);
            check($sformatf("rr.rsp_data%0d", k), 64'(bus.rsp_data_o), 64'hA0 + 64'(k));
            bus.rsp_rdy_i = 4'b1111;
            tick();
            bus.rsp_rdy_i = '0;
        end
        check("rr.outstanding0", 64'(bus.outstanding_o), 64'h0);

        // Tag full: fill 4 tags, then ch1 alloc stalls while ch3 free goes through.
        bus.req_val_i         = 4'b1111;
        bus.alloc_fifo_read_i = 1'b1;
        for (int c = 0; c < 4; c++) set_data(c, 64'h30 + 64'(c));
        for (int k = 0; k < 4; k++) tick();
        bus.req_val_i = '0;
        tick();
        idle();
        check("full.outstanding4", 64'(bus.outstanding_o), 64'h4);
        bus.req_val_i     = 4'b1010;
        bus.req_is_free_i = 4'b1000;
        set_data(1, 64'h60);
        set_data(3, 64'h2000);
        #1 check("full.free_grant", 64'(bus.req_rdy_o), 64'h8);
        tick();
        bus.req_val_i = 4'b0010;
        check("full.free_empty", 64'(bus.free_fifo_empty_o), 64'h0);
        check("full.free_dout", 64'(bus.free_fifo_dout_o), 64'h2000);
        #1 check("full.alloc_stall", 64'(bus.req_rdy_o), 64'h0);
        bus.resp_fifo_write_i = 1'b1;
        bus.resp_fifo_din_i   = 64'hB0;
        #1 check("full.stall_prepop", 64'(bus.req_rdy_o), 64'h0);
        tick();
        bus.resp_fifo_write_i = 1'b0;
        check("full.rsp_val", 64'(bus.rsp_val_o), 64'h1);
        check("full.rsp_data", 64'(bus.rsp_data_o), 64'hB0);
        check("full.outstanding3", 64'(bus.outstanding_o), 64'h3);
        #1 check("full.ch1_granted", 64'(bus.req_rdy_o), 64'h2);
        tick();
        idle();
        check("full.outstanding_refill", 64'(bus.outstanding_o), 64'h4);
        check("full.alloc_dout", 64'(bus.alloc_fifo_dout_o), 64'h60);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Underflow: response with nothing outstanding.
        bus.resp_fifo_write_i = 1'b1;
        bus.resp_fifo_din_i   = 64'hDEAD;
        tick();
        idle();
        check("uflow.flag", 64'(bus.tag_underflow_o), 64'h1);
        check("uflow.rsp_val", 64'(bus.rsp_val_o), 64'h0);
        check("uflow.resp_full", 64'(bus.resp_fifo_full_o), 64'h0);
        tick();
        check("uflow.sticky", 64'(bus.tag_underflow_o), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("uflow.reset_clears", 64'(bus.tag_underflow_o), 64'h0);

        // Priority: ch0 alloc vs ch1 free with rr = 0.
`ifdef FALAFEL_ARB_FREE_FIRST_EN
        exp_first = 4'b0010;
`else
        exp_first = 4'b0001;
`endif
        bus.req_val_i     = 4'b0011;
        bus.req_is_free_i = 4'b0010;
        set_data(0, 64'h50);
        set_data(1, 64'h3000);
        #1 check("prio.first", 64'(bus.req_rdy_o), 64'(exp_first));
        tick();
        bus.req_val_i = 4'b0011 & ~exp_first;
        #1 check("prio.second", 64'(bus.req_rdy_o), 64'(4'b0011 ^ exp_first));
        tick();
        idle();
        check("prio.alloc_dout", 64'(bus.alloc_fifo_dout_o), 64'h50);
        check("prio.free_dout", 64'(bus.free_fifo_dout_o), 64'h3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/falafel_req_arbiter.md
# falafel_req_arbiter

Multi-client front end for the falafel allocator core. It arbitrates alloc and free requests from `NUM_CH` independent client channels onto the core's alloc/free FIFO read interfaces. It remembers the issuing channel of every outstanding alloc in an order (tag) FIFO, and routes each core response back to the channel that issued the alloc. It sits between the client crossbar and `falafel_core`, and replaces the three per-core FIFOs with FIFO-compatible slots.

## Interface
Parameters:
- `NUM_CH`, 4 — client channel count, ≥2.
- `DATA_W`, 64 — request/response data width; matches `falafel_pkg::DATA_W`.
- `TAG_DEPTH`, 8 — maximum outstanding allocs; power of two, ≥2.

Ports (clock and reset first):
- `clk_i` in 1 — single clock.
- `rst_i` in 1 — reset; synchronous, active-high.
- `req_val_i` in NUM_CH — client request valid.
- `req_is_free_i` in NUM_CH — 1 = free, 0 = alloc.
- `req_data_i` in NUM_CH*DATA_W — alloc size or free pointer; channel c occupies bits [c*DATA_W +: DATA_W].
- `req_rdy_o` out NUM_CH — request accepted (one-hot or zero).
- `rsp_val_o` out NUM_CH — alloc response valid (one-hot or zero).
- `rsp_data_o` out DATA_W — response pointer, shared by all channels.
- `rsp_rdy_i` in NUM_CH — client response ready.
- `alloc_fifo_empty_o` / `alloc_fifo_read_i` / `alloc_fifo_dout_o` — out 1 / in 1 / out DATA_W; core alloc FIFO.
- `free_fifo_empty_o` / `free_fifo_read_i` / `free_fifo_dout_o` — out 1 / in 1 / out DATA_W; core free FIFO.
- `resp_fifo_full_o` / `resp_fifo_write_i` / `resp_fifo_din_i` — out 1 / in 1 / in DATA_W; core response FIFO.
- `outstanding_o` out $clog2(TAG_DEPTH+1) — tag FIFO occupancy.
- `tag_underflow_o` out 1 — sticky error flag.

## Operation
- **Alloc slot and free slot.** Each is a one-entry register with a valid bit.
  - `*_fifo_empty_o` = !valid.
  - `*_fifo_dout_o` = slot data (first-word fall-through).
  - A read with empty=0 consumes the slot. A read while empty is ignored.
- **Eligibility of channel c:**
  - Free: `req_val_i[c] & req_is_free_i[c]` and (free slot empty or being read this cycle).
  - Alloc: `req_val_i[c] & !req_is_free_i[c]`, alloc slot empty or being read this cycle, and tag FIFO not full.
- **Grant.** At most one grant per cycle, combinational.
  - Round-robin over eligible channels, starting at pointer `rr`.
  - `req_rdy_o[g]` = 1 for the granted channel g only.
  - On grant: `rr <= (g+1) mod NUM_CH`, and the slot loads `req_data_i[g]`.
  - For an alloc grant, g is also pushed into the tag FIFO.
- **Response register.** It holds a valid bit, data, and a channel.
  - `resp_fifo_full_o` = valid.
  - On `resp_fifo_write_i & !full` with the tag FIFO non-empty: capture `resp_fifo_din_i`, set channel = tag head, pop the tag.
  - While valid: `rsp_val_o[channel]` = 1 and `rsp_data_o` = data. The register clears on `rsp_rdy_i[channel]`.
- **Tag FIFO empty.** A `resp_fifo_write_i` with an empty tag FIFO is dropped and sets `tag_underflow_o`, which is cleared only by reset.
- **Simultaneous push and pop.** A tag push and pop in the same cycle leave occupancy unchanged. Push is allowed when full only if a pop occurs that cycle; eligibility uses the pre-pop count, so a full FIFO still blocks allocs.
- **Reset, including mid-operation.** All slots, tags, the response register and `rr` are cleared. In-flight requests are discarded.

## Timing
- Reset values:
  - `req_rdy_o` = 0, `rsp_val_o` = 0, `rsp_data_o` = 0.
  - `alloc_fifo_empty_o` = 1, `free_fifo_empty_o` = 1, `resp_fifo_full_o` = 0.
  - Both `dout` outputs = 0, `outstanding_o` = 0, `tag_underflow_o` = 0.
- Request accepted in cycle t → slot non-empty at t+1.
- Slot read at t plus a new grant at t → new data at t+1, giving one request per cycle of throughput.
- Core response write at t → `rsp_val_o` at t+1.
- Response held at t with `rsp_rdy_i` → `resp_fifo_full_o` = 0 at t+1.
- No combinational path from `rsp_rdy_i` to `resp_fifo_full_o`.
- `req_rdy_o` depends on `req_val_i`. Clients must not make `req_val_i` depend on `req_rdy_o`.
- `outstanding_o` is registered and increments the cycle after an alloc grant.

## Configuration
- `FALAFEL_ARB_FREE_FIRST_EN` defined:
  - If any free is eligible, the grant is round-robin among eligible frees only (same `rr` pointer).
  - Allocs are granted only in cycles with no eligible free.
- Undefined: one unified round-robin over all eligible requests, regardless of type.

## Test plan
- **Reset:** assert `rst_i` mid-traffic with 3 tags outstanding → next cycle all outputs at reset values and `outstanding_o` = 0.
- **Single alloc:** ch2 alloc size 0x40 at t → `req_rdy_o` = 4'b0100 at t; `alloc_fifo_dout_o` = 0x40 and empty = 0 at t+1. Core writes 0x1000 → `rsp_val_o` = 4'b0100 and `rsp_data_o` = 0x1000 one cycle later.
- **Round-robin routing:** all 4 channels alloc continuously, core reads every cycle → grants ch0,1,2,3 on consecutive cycles. Responses 0xA0..0xA3 go to ch0..ch3 in order.
- **Tag full (TAG_DEPTH=4):** 4 allocs outstanding; ch1 alloc stalls (`req_rdy_o[1]` = 0) while ch3 free 0x2000 is granted. After one response, ch1 is granted the next cycle.
- **Underflow:** `resp_fifo_write_i` with `outstanding_o` = 0 → `tag_underflow_o` = 1 and stays set; `rsp_val_o` remains 0.
- **Priority mode:** `rr` = 0, ch0 alloc and ch1 free asserted together → macro undefined grants ch0 first; macro defined grants ch1 first.
